// File: rtl/pdm_pkg.sv
// Shared widths, saturation helper and modulator-order selection for the PDM transmitter.
// Optional feature macro: PDM_TX_ORDER2_EN selects the second-order modulator.
package pdm_pkg;

    typedef enum logic {
        SDM_ORDER1 = 1'b0,
        SDM_ORDER2 = 1'b1
    } sdm_order_e;

`ifdef PDM_TX_ORDER2_EN
    localparam sdm_order_e SDM_ORDER = SDM_ORDER2;
`else
    localparam sdm_order_e SDM_ORDER = SDM_ORDER1;
`endif

    // CIC register width: input width plus worst-case growth of the integrators.
    function automatic int CIC_W(int dw, int n, int r);
        return dw + n * $clog2(r);
    endfunction

    // Right shift that removes the interpolator DC gain R^(N-1).
    function automatic int SHIFT(int n, int r);
        return (n - 1) * $clog2(r);
    endfunction

    // Second-order modulator state width.
    function automatic int SDM_W(int dw);
        return dw + 3;
    endfunction

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat(logic signed [63:0] v, int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// Sample input handshake between a PCM source and the PDM transmitter.
interface pdm_tx_if #(parameter int DW = 16) ();
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pdm_sdm.sv
// Delta-sigma modulator turning a DW-bit signed level into a 1-bit registered stream.
// PDM_TX_ORDER2_EN selects the second-order error-feedback loop; default is first order.
module pdm_sdm
    import pdm_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] y_i,
    output logic                 dout_o
);

`ifdef PDM_TX_ORDER2_EN
    localparam int                SW   = SDM_W(DW);
    localparam logic signed [63:0] HALF = 64'sd1 <<< (DW - 1);

    logic signed [SW-1:0] v1_q, v1_d;
    logic signed [SW-1:0] v2_q, v2_d;
    logic                 dout_q, dout_d;
    logic signed [63:0]   fb;

    // Two saturating integrators; v2 takes the updated v1 and the quantizer sees the
    // updated v2, giving a noise transfer of (1-z^-1)^2.
    always_comb begin
        fb     = dout_q ? HALF : -HALF;
        v1_d   = SW'(sat(64'(v1_q) + 64'(y_i) - fb, SW));
        v2_d   = SW'(sat(64'(v2_q) + 64'(v1_d) - fb, SW));
        dout_d = !v2_d[SW-1];
    end

    // Modulator state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= '0;
            v2_q   <= '0;
            dout_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;
`else
    logic [DW:0]   acc_q, acc_d;
    logic [DW-1:0] u;

    // Offset-binary level accumulated modulo 2^DW; the carry out is the PDM bit.
    always_comb begin
        u     = {~y_i[DW-1], y_i[DW-2:0]};
        acc_d = {1'b0, acc_q[DW-1:0]} + {1'b0, u};
    end

    // Accumulator register; its top bit is the registered output.
    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign dout_o = acc_q[DW];
`endif

endmodule

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: one-entry sample holding register, slot phase counter,
// N-stage CIC interpolator by R, rescale/saturate, then pdm_sdm.
// PDM_TX_ORDER2_EN (see pdm_sdm) swaps in the second-order modulator.
module pdm_tx
    import pdm_pkg::*;
#(
    parameter int DW = 16,
    parameter int R  = 64,
    parameter int N  = 3
) (
    input  logic     clk,
    input  logic     reset,
    pdm_tx_if.slave  bus,
    output logic     dout,
    output logic     underrun
);

    localparam int LR = $clog2(R);
    localparam int CW = DW + N;
    localparam int W  = CIC_W(DW, N, R);
    localparam int SH = SHIFT(N, R);

    logic [LR-1:0]        phase_q, phase_d;
    logic                 held_q, held_d;
    logic signed [DW-1:0] hold_q, hold_d;
    logic signed [DW-1:0] last_q, last_d;
    logic                 underrun_q, underrun_d;
    logic                 consume, xfer;
    logic signed [DW-1:0] x_slow;

    logic signed [CW-1:0] dly_q [N];
    logic signed [CW-1:0] dly_d [N];
    logic signed [CW-1:0] cstg  [N+1];
    logic signed [CW-1:0] c_q, c_d;

    logic signed [W-1:0]  integ_q [N];
    logic signed [W-1:0]  integ_d [N];
    logic signed [W-1:0]  istuff;
    logic signed [W-1:0]  ishift;
    logic signed [DW-1:0] y_q, y_d;

    assign consume      = (phase_q == LR'(R - 1));
    assign xfer         = bus.in_valid && !held_q;
    assign bus.in_ready = !held_q;
    assign underrun     = underrun_q;

    // Handshake and slot consumption; an empty slot repeats the last value.
    always_comb begin
        phase_d    = phase_q + 1'b1;
        x_slow     = held_q ? hold_q : last_q;
        held_d     = held_q;
        hold_d     = hold_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        if (consume) begin
            last_d     = x_slow;
            held_d     = 1'b0;
            underrun_d = !held_q;
        end
        if (xfer) begin
            held_d = 1'b1;
            hold_d = bus.in_data;
        end
    end

    // Comb differentiators at the slow rate, advanced only on the consume edge.
    always_comb begin
        cstg[0] = CW'(x_slow);
        for (int k = 0; k < N; k++) begin
            cstg[k+1] = cstg[k] - dly_q[k];
            dly_d[k]  = consume ? cstg[k] : dly_q[k];
        end
        c_d = consume ? cstg[N] : c_q;
    end

    // Zero-stuffed integrators (modular arithmetic) followed by gain removal and clamp.
    always_comb begin
        istuff = '0;
        if (phase_q == '0) istuff = W'(c_q);
        integ_d[0] = integ_q[0] + istuff;
        for (int k = 1; k < N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
        ishift = integ_q[N-1] >>> SH;
        y_d    = DW'(sat(64'(ishift), DW));
    end

    // All transmitter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            held_q     <= 1'b0;
            hold_q     <= '0;
            last_q     <= '0;
            underrun_q <= 1'b0;
            c_q        <= '0;
            y_q        <= '0;
            for (int k = 0; k < N; k++) begin
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
        end else begin
            phase_q    <= phase_d;
            held_q     <= held_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
            c_q        <= c_d;
            y_q        <= y_d;
            for (int k = 0; k < N; k++) begin
                dly_q[k]   <= dly_d[k];
                integ_q[k] <= integ_d[k];
            end
        end
    end

    pdm_sdm #(.DW(DW)) u_sdm (
        .clk    (clk),
        .reset  (reset),
        .y_i    (y_q),
        .dout_o (dout)
    );

endmodule

// File: tb/tb_pdm_tx.sv
// Bench for pdm_tx: a holding-register scoreboard predicts handshake/underrun,
// level tests check the settled scaled value and the PDM ones density.
module tb_pdm_tx;
    localparam int DW = 16;
    localparam int R  = 64;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic reset;
    logic dout, underrun;

    pdm_tx_if #(.DW(DW)) bus ();

    pdm_tx #(.DW(DW), .R(R), .N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dout     (dout),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] sb_q[$];
    logic signed [DW-1:0] m_last;
    int   ph;
    logic exp_unr, exp_rdy;
    int   dut_xfers;

    // One clock: drive at the negedge, advance the model on the posedge, return at negedge.
    task automatic tick(input logic v, input logic signed [DW-1:0] d);
        logic xfer, cons;
        bus.in_valid = v;
        bus.in_data  = d;
        xfer = v && exp_rdy;
        if (v && bus.in_ready) dut_xfers++;
        cons = (ph == R - 1);
        @(posedge clk);
        exp_unr = 1'b0;
        if (cons) begin
            if (sb_q.size() > 0) m_last = sb_q.pop_front();
            else exp_unr = 1'b1;
        end
        if (xfer) sb_q.push_back(d);
        exp_rdy = (sb_q.size() == 0);
        ph = (ph + 1) % R;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_last = '0; ph = 0; exp_unr = 1'b0; exp_rdy = 1'b1; dut_xfers = 0;
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int i = 0; i < 150; i++) tick(1'b1, 16'sh3000);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (dout !== 1'b0 || bus.in_ready !== 1'b1 || underrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: dout=%b in_ready=%b underrun=%b want 0/1/0", dout, bus.in_ready, underrun);
            end
        end
        reset = 1'b0;
        sb_q.delete();
        m_last = '0; ph = 0; exp_unr = 1'b0; exp_rdy = 1'b1; dut_xfers = 0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut.integ_q[k] !== '0) begin
                errors++;
                $display("FAIL reset_integ%0d: got %0d want 0", k, dut.integ_q[k]);
            end
        end
        checks++;
        if (dut.y_q !== '0 || dout !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: y=%0d dout=%b in_ready=%b want 0/0/1", dut.y_q, dout, bus.in_ready);
        end
    endtask

    // Constant level supplied every slot: check handshake, settled y and ones density.
    task automatic test_level(input logic signed [DW-1:0] x, input int exp_ones, input logic alt);
        int ones, bad_alt;
        logic prev;
        do_reset(3);
        for (int i = 0; i < 512; i++) begin
            tick(1'b1, x);
            checks++;
            if (underrun !== exp_unr || bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL level_hs: cyc %0d underrun=%b in_ready=%b want %b/%b", i, underrun, bus.in_ready, exp_unr, exp_rdy);
            end
        end
        checks++;
        if (dut.y_q !== m_last) begin
            errors++;
            $display("FAIL level_y: got %0d want %0d", dut.y_q, m_last);
        end
        while (ph % 4 != 0) tick(1'b1, x);
        ones = 0; bad_alt = 0; prev = dout;
        for (int i = 0; i < 1024; i++) begin
            tick(1'b1, x);
            ones += int'(dout);
            if (dout === prev) bad_alt++;
            prev = dout;
        end
        checks++;
        if (ones != exp_ones) begin
            errors++;
            $display("FAIL level_ones x=%0d: got %0d want %0d", x, ones, exp_ones);
        end
        if (alt) begin
            checks++;
            if (bad_alt != 0) begin
                errors++;
                $display("FAIL level_alternate: %0d repeated bits want 0", bad_alt);
            end
        end
    endtask

    task automatic test_handshake();
        do_reset(3);
        for (int i = 0; i < 10 * R; i++) begin
            tick(1'b1, DW'(i * 37));
            checks++;
            if (bus.in_ready !== exp_rdy || underrun !== 1'b0) begin
                errors++;
                $display("FAIL hs_cycle: cyc %0d in_ready=%b underrun=%b want %b/0", i, bus.in_ready, underrun, exp_rdy);
            end
        end
        checks++;
        if (dut_xfers != 10) begin
            errors++;
            $display("FAIL hs_transfers: got %0d want 10", dut_xfers);
        end
    endtask

    task automatic test_underrun();
        int pulses;
        do_reset(3);
        for (int i = 0; i < 6 * R; i++) tick(1'b1, 16'sh2000);
        pulses = 0;
        for (int i = 0; i < 8 * R; i++) begin
            tick(1'b0, '0);
            pulses += int'(underrun);
            checks++;
            if (underrun !== exp_unr) begin
                errors++;
                $display("FAIL unr_cycle: cyc %0d got %b want %b", i, underrun, exp_unr);
            end
        end
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL unr_count: got %0d want 8", pulses);
        end
        checks++;
        if (dut.y_q !== 16'sd8192) begin
            errors++;
            $display("FAIL unr_hold_y: got %0d want 8192", dut.y_q);
        end
        while (ph != R - 1) tick(1'b0, '0);
        tick(1'b1, 16'sh1000);
        checks++;
        if (underrun !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL unr_edge_offer: underrun=%b in_ready=%b want 1/0", underrun, bus.in_ready);
        end
        for (int i = 0; i < 5 * R; i++) begin
            tick(1'b0, '0);
            checks++;
            if (underrun !== exp_unr || bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL unr_after: cyc %0d underrun=%b in_ready=%b want %b/%b", i, underrun, bus.in_ready, exp_unr, exp_rdy);
            end
        end
        checks++;
        if (dut.y_q !== 16'sd4096 || m_last !== 16'sh1000) begin
            errors++;
            $display("FAIL unr_new_y: got %0d want 4096", dut.y_q);
        end
    endtask

`ifdef PDM_TX_ORDER2_EN
    task automatic test_order2();
        int ones, sat_hits;
        localparam int SW = DW + 3;
        do_reset(3);
        for (int i = 0; i < 512; i++) tick(1'b1, 16'sh4000);
        ones = 0; sat_hits = 0;
        for (int i = 0; i < 4096; i++) begin
            tick(1'b1, 16'sh4000);
            ones += int'(dout);
            if (dut.u_sdm.v1_q == {1'b0, {(SW-1){1'b1}}} || dut.u_sdm.v1_q == {1'b1, {(SW-1){1'b0}}} ||
                dut.u_sdm.v2_q == {1'b0, {(SW-1){1'b1}}} || dut.u_sdm.v2_q == {1'b1, {(SW-1){1'b0}}})
                sat_hits++;
        end
        checks++;
        if (ones < 3068 || ones > 3076) begin
            errors++;
            $display("FAIL order2_ones: got %0d want 3072+-4", ones);
        end
        checks++;
        if (sat_hits != 0) begin
            errors++;
            $display("FAIL order2_sat: got %0d saturated cycles want 0", sat_hits);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        test_reset();
`ifdef PDM_TX_ORDER2_EN
        test_order2();
`else
        test_level(16'sh4000, 768, 1'b0);
        test_level(16'sh0000, 512, 1'b1);
        test_level(16'sh8000, 0, 1'b0);
`endif
        test_handshake();
        test_underrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
